// File: rtl/sdram_bist_dump_if.sv
// ---------------------------------------------------------------------------
// sdram_bist_dump_if
//   Call/done handshake bundle between the SDRAM self-test engine and
//   sdram_basemod.
//   oCall   [1]=write request, [0]=read request (engine -> basemod)
//   iDone   [1]=write done,    [0]=read done, 1-cycle pulses (basemod -> engine)
//   oAddr   SDRAM word address, stable while a call bit is high
//   oWrData write data, stable while oCall[1] is high
//   iRdData read data, valid in the cycle iDone[0] is high
// ---------------------------------------------------------------------------
interface sdram_bist_dump_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [1:0]        oCall;
    logic [1:0]        iDone;
    logic [ADDR_W-1:0] oAddr;
    logic [DATA_W-1:0] oWrData;
    logic [DATA_W-1:0] iRdData;

    modport master (output oCall, oAddr, oWrData, input iDone, iRdData);
    modport slave  (input oCall, oAddr, oWrData, output iDone, iRdData);
endinterface

// File: rtl/sdram_bist_dump.sv
// ---------------------------------------------------------------------------
// sdram_bist_dump
//   SDRAM self-test and dump engine. Writes a selectable pattern over a
//   window of WORD_COUNT words starting at START_ADDR, reads the window back,
//   compares every word and optionally streams each read word out of an
//   8N2 UART (high byte first, BAUD_DIV clocks per bit).
//   CLOCK     system clock (rising edge)
//   RESET     asynchronous, active-low reset
//   iStart    start pulse, honoured only when idle
//   iMode     pattern: 0=16'hA5A5, 1=addr[15:0], 2=walking one, 3=~addr[15:0]
//   iDumpEn   send read words over TXD (latched at start)
//   bus       call/done handshake towards sdram_basemod (master side)
//   TXD       UART serial output, idle high
//   oBusy     high from accepted start until the oDone pulse
//   oDone     1-cycle pulse at end of run
//   oPass     last run had zero mismatches (valid from oDone)
//   oErrCnt   saturating mismatch count
//   oErrAddr  address of first mismatch (0 if none)
// ---------------------------------------------------------------------------
module sdram_bist_dump #(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                WORD_COUNT = 512,
    parameter int                BAUD_DIV   = 1157,
    parameter int                ERR_W      = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               iStart,
    input  logic [1:0]         iMode,
    input  logic               iDumpEn,
    sdram_bist_dump_if.master  bus,
    output logic               TXD,
    output logic               oBusy,
    output logic               oDone,
    output logic               oPass,
    output logic [ERR_W-1:0]   oErrCnt,
    output logic [ADDR_W-1:0]  oErrAddr
);

    localparam int             K_W       = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [K_W-1:0] LAST_K    = K_W'(WORD_COUNT - 1);
    localparam int             BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, WR, RD, CHK, TXH, TXL, NXT, FIN} state_t;

    state_t            state;
    logic [K_W-1:0]    k;
    logic [1:0]        mode_r;
    logic              dump_r;
    logic [DATA_W-1:0] rd_data;
    logic [9:0]        tx_shift;
    logic [3:0]        bit_idx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [DATA_W-1:0] expect_word;
    logic              mismatch;

    // Pattern word for offset idx at address addr; walking one uses idx mod 16.
    function automatic logic [15:0] pattern(input logic [1:0] mode,
                                            input logic [K_W-1:0] idx,
                                            input logic [ADDR_W-1:0] addr);
        logic [15:0] addr_lo;
        logic [3:0]  idx_lo;
        addr_lo = 16'(addr);
        idx_lo  = 4'(idx);
        case (mode)
            2'd0:    pattern = 16'hA5A5;
            2'd1:    pattern = addr_lo;
            2'd2:    pattern = 16'd1 << idx_lo;
            default: pattern = ~addr_lo;
        endcase
    endfunction

    // oAddr always holds the address of offset k, so the same expected word
    // serves both as write data and as the read-back reference.
    always_comb begin
        expect_word = pattern(mode_r, k, bus.oAddr);
        mismatch    = (rd_data != expect_word);
    end

    // Single sequencer: SDRAM handshake, compare, UART framing and status.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            bus.oCall   <= '0;
            bus.oAddr   <= '0;
            bus.oWrData <= '0;
            TXD         <= 1'b1;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oPass       <= 1'b0;
            oErrCnt     <= '0;
            oErrAddr    <= '0;
            k           <= '0;
            mode_r      <= '0;
            dump_r      <= 1'b0;
            rd_data     <= '0;
            tx_shift    <= '0;
            bit_idx     <= '0;
            baud_cnt    <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        mode_r    <= iMode;
                        dump_r    <= iDumpEn;
                        oErrCnt   <= '0;
                        oErrAddr  <= '0;
                        oPass     <= 1'b0;
                        k         <= '0;
                        bus.oAddr <= START_ADDR;
                        oBusy     <= 1'b1;
                        state     <= WR;
                    end
                end
                WR: begin
                    // Address was set while the call was low; data goes out with the call.
                    if (!bus.oCall[1]) begin
                        bus.oCall[1] <= 1'b1;
                        bus.oWrData  <= expect_word;
                    end else if (bus.iDone[1]) begin
                        bus.oCall[1] <= 1'b0;
                        if (k == LAST_K) begin
                            k         <= '0;
                            bus.oAddr <= START_ADDR;
                            state     <= RD;
                        end else begin
                            k         <= k + 1'b1;
                            bus.oAddr <= bus.oAddr + 1'b1;
                        end
                    end
                end
                RD: begin
                    if (!bus.oCall[0]) begin
                        bus.oCall[0] <= 1'b1;
                    end else if (bus.iDone[0]) begin
                        bus.oCall[0] <= 1'b0;
                        rd_data      <= bus.iRdData;
                        state        <= CHK;
                    end
                end
                CHK: begin
                    // A zero count means no earlier mismatch, since the count saturates.
                    if (mismatch) begin
                        if (oErrCnt == '0) oErrAddr <= bus.oAddr;
                        if (oErrCnt != '1) oErrCnt <= oErrCnt + 1'b1;
                    end
                    if (dump_r) begin
                        TXD      <= 1'b0;
                        tx_shift <= {2'b11, rd_data[15:8]};
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        state    <= TXH;
                    end else begin
                        state <= NXT;
                    end
                end
                TXH, TXL: begin
                    // bit_idx counts bits shifted out after the start bit; at 10 the
                    // second stop bit has just completed its full bit time.
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx != 4'd10) begin
                            TXD      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[9:1]};
                            bit_idx  <= bit_idx + 1'b1;
                        end else if (state == TXH) begin
                            TXD      <= 1'b0;
                            tx_shift <= {2'b11, rd_data[7:0]};
                            bit_idx  <= '0;
                            state    <= TXL;
                        end else begin
                            TXD   <= 1'b1;
                            state <= NXT;
                        end
                    end
                end
                NXT: begin
                    if (k == LAST_K) begin
                        state <= FIN;
                    end else begin
                        k         <= k + 1'b1;
                        bus.oAddr <= bus.oAddr + 1'b1;
                        state     <= RD;
                    end
                end
                FIN: begin
                    oPass <= (oErrCnt == '0);
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
